seg7_scan_disp: RTL and testbench
=================================

SEG7_SCAN_DISP -- requirements
Module: seg7_scan_disp

Interface
REQ-001 The block SHALL provide parameter SCAN_DIV, default 100000, giving clk cycles per digit slot; legal range 2 to 2^20.
REQ-002 The block SHALL provide parameter BLINK_BITS, default 26, giving the width of the blink phase counter; it is used only with SEG7_BLINK_EN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port hexs, input, 16 bits: four hex digits; digit k = hexs[4k+3:4k], and digit 0 is rightmost.
REQ-006 The block SHALL have port points, input, 4 bits: points[k]=1 lights the decimal point of digit k.
REQ-007 The block SHALL have port les, input, 4 bits: les[k]=1 blanks digit k (or blinks it, per REQ-025).
REQ-008 The block SHALL have port an, output, 4 bits: active-low anode select; an[k]=0 enables digit k.
REQ-009 The block SHALL have port segment, output, 8 bits: active-low cathodes; bit7 = dp, bits6..0 = g,f,e,d,c,b,a.

Function
REQ-010 A tick counter SHALL count 0..SCAN_DIV-1 and then wrap; tick = (counter == SCAN_DIV-1).
REQ-011 A valid flag (reset 0) and a 2-bit digit index (reset 3) SHALL advance on each tick:
- index 3→0 wraps, and the wrap also sets valid=1;
- otherwise index increments.
REQ-012 On every tick where the index wraps 3→0, including the first tick after reset, hexs/points/les SHALL be captured into shadow registers.
REQ-013 Shadow registers SHALL be the only source for display; input changes mid-frame SHALL NOT appear until the next frame.
REQ-014 While valid=0, outputs SHALL hold an=4'b1111 and segment=8'hFF.
REQ-015 Outputs an and segment SHALL be registered and reflect the index/shadow state one clk after the tick edge.
REQ-016 When valid=1, an SHALL equal the bitwise complement of (1 << index), with exactly one anode low.
REQ-017 Segment bits6..0 SHALL decode the shadow digit:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78 (hex, 7-bit);
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex, 7-bit).
REQ-018 segment[7] SHALL equal the inverted shadow points[index].
REQ-019 A blanked digit SHALL drive segment=8'hFF (dp included) while its anode is still driven low.

Reset
REQ-020 rst_n=0 sampled on a clk edge SHALL, on that edge:
- clear the tick counter, valid flag and all shadow registers;
- set the index to 3;
- set an=4'b1111 and segment=8'hFF.
REQ-021 Reset asserted mid-frame SHALL abort the scan; the first tick after release SHALL occur on the SCAN_DIV-th edge with rst_n=1.
REQ-022 Reset SHALL take priority over a simultaneous tick.

Configuration
REQ-023 Macro SEG7_BLINK_EN SHALL select blink support at compile time.
REQ-024 Without SEG7_BLINK_EN:
- les[k]=1 blanks digit k continuously;
- no blink counter is instantiated.
REQ-025 With SEG7_BLINK_EN:
- a free-running BLINK_BITS-wide counter (reset 0) SHALL exist;
- digit k with shadow les[k]=1 is blanked only while the counter MSB=1 and shown normally otherwise.

Verification (SCAN_DIV=4)
REQ-026 Startup: hexs=16'h1234, points=0, les=0, release reset → an=1111/seg=FF through edge 4; from edge 5 an=1110, seg=8'h99; from edge 9 an=1101, seg=8'hB0.
REQ-027 Frame coherency: hexs→16'hABCD while digit 1 is shown → digits 2 and 3 show seg A4 and F9; the next frame shows digit 0 as seg A1 (d).
REQ-028 Decimal point: points=4'b0010, hexs=16'h1234 → digit 1 seg=8'h30, all other digits have bit7=1.
REQ-029 Blanking: les=4'b0001 without the macro → during slot 0, an=1110 and seg=FF in every frame.
- With SEG7_BLINK_EN and BLINK_BITS=5, digit 0 alternates between 8'h99 and 8'hFF every 16 cycles.
REQ-030 Mid-scan reset: rst_n=0 for one edge during digit 2 → an=1111/seg=FF on that edge; restart timing matches REQ-026.
REQ-031 Code table: hexs=16'h8F0E → digits 0..3 show seg 86, C0, 8E, 80.

Source files
------------

// File: rtl/seg7_scan_disp.sv
// rtl/seg7_scan_disp.sv - four-digit multiplexed 7-segment display scanner
//
// Purpose: scans four hex digits onto a common-anode 7-segment display.
// Each digit is shown for SCAN_DIV clk cycles. Inputs are captured into
// shadow registers once per frame, so a frame is always drawn from one
// consistent snapshot.
//
// Optional feature macro: SEG7_BLINK_EN. When it is defined, digits whose
// les bit is set blink, driven by a BLINK_BITS-wide phase counter. When it
// is not defined, those digits are blanked continuously.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   hexs     in  16  digit k = hexs[4k+3:4k], digit 0 rightmost
//   points   in   4  points[k]=1 lights the decimal point of digit k
//   les      in   4  les[k]=1 blanks (or blinks) digit k
//   an       out  4  active-low anode select
//   segment  out  8  active-low cathodes {dp,g,f,e,d,c,b,a}
module seg7_scan_disp #(
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_BITS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] hexs,
  input  logic [3:0]  points,
  input  logic [3:0]  les,
  output logic [3:0]  an,
  output logic [7:0]  segment
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic [1:0]    r_idx;
  logic [15:0]   r_hex_sh;
  logic [3:0]    r_pts_sh;
  logic [3:0]    r_les_sh;
  logic [3:0]    r_an;
  logic [7:0]    r_seg;

  logic          w_tick;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg7;
  logic          w_blank;

  assign w_tick  = (r_cnt == LP_LAST);
  assign w_digit = r_hex_sh[{r_idx, 2'b00} +: 4];

  // Slot timer, digit index and per-frame input snapshot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_idx    <= 2'd3;
      r_hex_sh <= '0;
      r_pts_sh <= '0;
      r_les_sh <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        if (r_idx == 2'd3) begin
          // Frame boundary: the index starts at 3 so that the first tick
          // after reset lands here and captures the first snapshot.
          r_idx    <= 2'd0;
          r_valid  <= 1'b1;
          r_hex_sh <= hexs;
          r_pts_sh <= points;
          r_les_sh <= les;
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end
    end
  end

  // Active-low {g,f,e,d,c,b,a}
  always_comb begin
    w_seg7 = 7'h7F;
    case (w_digit)
      4'h0: w_seg7 = 7'h40;
      4'h1: w_seg7 = 7'h79;
      4'h2: w_seg7 = 7'h24;
      4'h3: w_seg7 = 7'h30;
      4'h4: w_seg7 = 7'h19;
      4'h5: w_seg7 = 7'h12;
      4'h6: w_seg7 = 7'h02;
      4'h7: w_seg7 = 7'h78;
      4'h8: w_seg7 = 7'h00;
      4'h9: w_seg7 = 7'h10;
      4'hA: w_seg7 = 7'h08;
      4'hB: w_seg7 = 7'h03;
      4'hC: w_seg7 = 7'h46;
      4'hD: w_seg7 = 7'h21;
      4'hE: w_seg7 = 7'h06;
      4'hF: w_seg7 = 7'h0E;
      default: w_seg7 = 7'h7F;
    endcase
  end

`ifdef SEG7_BLINK_EN
  logic [BLINK_BITS-1:0] r_blink;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink <= '0;
    end else begin
      r_blink <= r_blink + 1'b1;
    end
  end

  // Blink-enabled digits go dark during the upper half of the blink period
  assign w_blank = r_les_sh[r_idx] & r_blink[BLINK_BITS-1];
`else
  localparam int LP_UNUSED_BLINK_BITS = BLINK_BITS;
  assign w_blank = r_les_sh[r_idx];
`endif

  // Registered drive: outputs follow the index/shadow state one clk later
  always_ff @(posedge clk) begin
    if (!rst_n || !r_valid) begin
      r_an  <= 4'b1111;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      // A blanked digit keeps its anode enabled but lights nothing
      r_seg <= w_blank ? 8'hFF : {~r_pts_sh[r_idx], w_seg7};
    end
  end

  assign an      = r_an;
  assign segment = r_seg;

endmodule

// File: tb/tb_seg7_scan_disp.sv
// tb/tb_seg7_scan_disp.sv - directed self-checking bench for seg7_scan_disp
module tb_seg7_scan_disp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hexs = 16'h0000;
  logic [3:0]  points = 4'h0;
  logic [3:0]  les = 4'h0;
  logic [3:0]  an;
  logic [7:0]  segment;

  int checks = 0;
  int errors = 0;

  seg7_scan_disp #(.SCAN_DIV(4), .BLINK_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .hexs(hexs), .points(points),
    .les(les), .an(an), .segment(segment)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // After this, the next rising edge is edge 1 with rst_n=1
  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    hexs = 16'hFFFF; points = 4'hF; les = 4'h0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if ({an, segment} !== {4'b1111, 8'hFF}) begin
        errors++;
        $display("FAIL reset_hold: got an=%b seg=%h want an=1111 seg=ff", an, segment);
      end
    end
  endtask

  task automatic test_startup();
    hexs = 16'h1234; points = 4'h0; les = 4'h0;
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      step(1);
      checks++;
      if ({an, segment} !== {4'b1111, 8'hFF}) begin
        errors++;
        $display("FAIL startup_idle edge %0d: got an=%b seg=%h want an=1111 seg=ff", e, an, segment);
      end
    end
    for (int e = 5; e <= 8; e++) begin
      step(1);
      checks++;
      if ({an, segment} !== {4'b1110, 8'h99}) begin
        errors++;
        $display("FAIL startup_d0 edge %0d: got an=%b seg=%h want an=1110 seg=99", e, an, segment);
      end
    end
    step(1);
    checks++;
    if ({an, segment} !== {4'b1101, 8'hB0}) begin
      errors++;
      $display("FAIL startup_d1 edge 9: got an=%b seg=%h want an=1101 seg=b0", an, segment);
    end
  endtask

  task automatic test_coherency();
    hexs = 16'h1234; points = 4'h0; les = 4'h0;
    do_reset();
    step(9);
    checks++;
    if ({an, segment} !== {4'b1101, 8'hB0}) begin
      errors++;
      $display("FAIL coh_d1: got an=%b seg=%h want an=1101 seg=b0", an, segment);
    end
    hexs = 16'hABCD;
    step(4);
    checks++;
    if ({an, segment} !== {4'b1011, 8'hA4}) begin
      errors++;
      $display("FAIL coh_d2_old: got an=%b seg=%h want an=1011 seg=a4", an, segment);
    end
    step(4);
    checks++;
    if ({an, segment} !== {4'b0111, 8'hF9}) begin
      errors++;
      $display("FAIL coh_d3_old: got an=%b seg=%h want an=0111 seg=f9", an, segment);
    end
    step(4);
    checks++;
    if ({an, segment} !== {4'b1110, 8'hA1}) begin
      errors++;
      $display("FAIL coh_d0_new: got an=%b seg=%h want an=1110 seg=a1", an, segment);
    end
  endtask

  task automatic test_points();
    logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] exp_seg [4] = '{8'h99, 8'h30, 8'hA4, 8'hF9};
    hexs = 16'h1234; points = 4'b0010; les = 4'h0;
    do_reset();
    step(1);
    for (int k = 0; k < 4; k++) begin
      step(4);
      checks++;
      if ({an, segment} !== {exp_an[k], exp_seg[k]}) begin
        errors++;
        $display("FAIL dp_digit%0d: got an=%b seg=%h want an=%b seg=%h", k, an, segment, exp_an[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_blank();
    logic [7:0] exp_d0 [3];
`ifdef SEG7_BLINK_EN
    exp_d0 = '{8'h99, 8'hFF, 8'h99};
`else
    exp_d0 = '{8'hFF, 8'hFF, 8'hFF};
`endif
    hexs = 16'h1234; points = 4'h0; les = 4'b0001;
    do_reset();
    step(5);
    for (int f = 0; f < 3; f++) begin
      checks++;
      if ({an, segment} !== {4'b1110, exp_d0[f]}) begin
        errors++;
        $display("FAIL blank_d0 frame %0d: got an=%b seg=%h want an=1110 seg=%h", f, an, segment, exp_d0[f]);
      end
      if (f == 0) begin
        step(4);
        checks++;
        if ({an, segment} !== {4'b1101, 8'hB0}) begin
          errors++;
          $display("FAIL blank_d1: got an=%b seg=%h want an=1101 seg=b0", an, segment);
        end
        step(12);
      end else begin
        step(16);
      end
    end
    les = 4'h0;
  endtask

  task automatic test_midreset();
    hexs = 16'h1234; points = 4'h0; les = 4'h0;
    do_reset();
    step(13);
    checks++;
    if ({an, segment} !== {4'b1011, 8'hA4}) begin
      errors++;
      $display("FAIL midrst_d2: got an=%b seg=%h want an=1011 seg=a4", an, segment);
    end
    rst_n = 1'b0;
    step(1);
    checks++;
    if ({an, segment} !== {4'b1111, 8'hFF}) begin
      errors++;
      $display("FAIL midrst_edge: got an=%b seg=%h want an=1111 seg=ff", an, segment);
    end
    rst_n = 1'b1;
    step(4);
    checks++;
    if ({an, segment} !== {4'b1111, 8'hFF}) begin
      errors++;
      $display("FAIL midrst_idle4: got an=%b seg=%h want an=1111 seg=ff", an, segment);
    end
    step(1);
    checks++;
    if ({an, segment} !== {4'b1110, 8'h99}) begin
      errors++;
      $display("FAIL midrst_d0: got an=%b seg=%h want an=1110 seg=99", an, segment);
    end
    step(4);
    checks++;
    if ({an, segment} !== {4'b1101, 8'hB0}) begin
      errors++;
      $display("FAIL midrst_d1: got an=%b seg=%h want an=1101 seg=b0", an, segment);
    end
  endtask

  task automatic test_reset_tick();
    hexs = 16'h1234; points = 4'h0; les = 4'h0;
    do_reset();
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    checks++;
    if ({an, segment} !== {4'b1111, 8'hFF}) begin
      errors++;
      $display("FAIL rsttick_edge1: got an=%b seg=%h want an=1111 seg=ff", an, segment);
    end
    step(3);
    checks++;
    if ({an, segment} !== {4'b1111, 8'hFF}) begin
      errors++;
      $display("FAIL rsttick_edge4: got an=%b seg=%h want an=1111 seg=ff", an, segment);
    end
    step(1);
    checks++;
    if ({an, segment} !== {4'b1110, 8'h99}) begin
      errors++;
      $display("FAIL rsttick_edge5: got an=%b seg=%h want an=1110 seg=99", an, segment);
    end
  endtask

  task automatic test_codes();
    logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] exp_seg [4] = '{8'h86, 8'hC0, 8'h8E, 8'h80};
    hexs = 16'h8F0E; points = 4'h0; les = 4'h0;
    do_reset();
    step(1);
    for (int k = 0; k < 4; k++) begin
      step(4);
      checks++;
      if ({an, segment} !== {exp_an[k], exp_seg[k]}) begin
        errors++;
        $display("FAIL code_digit%0d: got an=%b seg=%h want an=%b seg=%h", k, an, segment, exp_an[k], exp_seg[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_coherency();
    test_points();
    test_blank();
    test_midreset();
    test_reset_tick();
    test_codes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
